// File: rtl/seq_demux.sv
// seq_demux: registered 1-to-N demultiplexer with one-entry slot per channel,
// broadcast delivery and saturating drop count for out-of-range selects.
module seq_demux #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel,
    output logic [7:0]              drop_cnt
);

    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [N_OUT];
    logic [N_OUT-1:0]  can_take;
    logic [N_OUT-1:0]  target;
    logic [N_OUT-1:0]  load;
    logic [N_OUT-1:0]  drain;
    logic              sel_ok;
    logic              accept;
    logic              drop;

    always_comb begin
        can_take = '0;
        target   = '0;
        sel_ok   = ({1'b0, in_sel} < N_OUT_W);
        for (int i = 0; i < N_OUT; i++) begin
            can_take[i] = !valid_q[i] || out_ready[i];
            target[i]   = in_bcast || (sel_ok && (in_sel == SEL_W'(i)));
        end
    end

    // Untargeted channels never gate in_ready, so a bad select is always taken
    assign in_ready = &(~target | can_take);
    assign accept   = in_valid && in_ready;
    assign drop     = accept && !in_bcast && !sel_ok;
    assign load     = target & {N_OUT{accept}};
    assign drain    = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (load[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= in_data;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            err_sel <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
    end

endmodule

// File: tb/tb_seq_demux.sv
// Bench for seq_demux: directed scenarios plus randomized traffic on a
// 4-channel and a 3-channel instance, checked against a slot-level model.
module tb_seq_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;

    logic        a_valid, a_ready, a_bcast, a_err;
    logic [1:0]  a_sel;
    logic [7:0]  a_data, a_cnt;
    logic [3:0]  a_ovalid, a_oready;
    logic [31:0] a_odata;

    logic        b_valid, b_ready, b_bcast, b_err;
    logic [1:0]  b_sel;
    logic [7:0]  b_data, b_cnt;
    logic [2:0]  b_ovalid, b_oready;
    logic [23:0] b_odata;

    seq_demux #(.DATA_W(8), .N_OUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_ready(a_ready), .in_sel(a_sel),
        .in_bcast(a_bcast), .in_data(a_data),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata),
        .err_sel(a_err), .drop_cnt(a_cnt)
    );

    seq_demux #(.DATA_W(8), .N_OUT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready), .in_sel(b_sel),
        .in_bcast(b_bcast), .in_data(b_data),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
        .err_sel(b_err), .drop_cnt(b_cnt)
    );

    // Reference: per-channel slot contents, last-drop flag, drop count
    logic       mv [2][4];
    logic [7:0] md [2][4];
    logic       merr [2];
    int         mcnt [2];

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] ordy(int d);
        return (d == 0) ? a_oready : {1'b0, b_oready};
    endfunction

    function automatic logic exp_rdy(int d);
        int n = nch(d);
        logic bc = (d == 0) ? a_bcast : b_bcast;
        int sel = (d == 0) ? int'(a_sel) : int'(b_sel);
        logic [3:0] r = ordy(d);
        logic ok = 1'b1;
        if (bc) begin
            for (int i = 0; i < n; i++) ok = ok && (!mv[d][i] || r[i]);
            return ok;
        end
        if (sel < n) return !mv[d][sel] || r[sel];
        return 1'b1;
    endfunction

    function automatic logic [3:0] pv(int d);
        logic [3:0] v = '0;
        for (int i = 0; i < nch(d); i++) v[i] = mv[d][i];
        return v;
    endfunction

    function automatic logic [31:0] pd(int d);
        logic [31:0] v = '0;
        for (int i = 0; i < nch(d); i++) v[i*8 +: 8] = md[d][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                mv[d][i] = 1'b0;
                md[d][i] = 8'h00;
            end
            merr[d] = 1'b0;
            mcnt[d] = 0;
        end
    endtask

    task automatic tick();
        logic acc [2];
        logic bc [2];
        int sel [2];
        logic [7:0] dat [2];
        logic [3:0] r [2];
        acc[0] = a_valid && exp_rdy(0);
        acc[1] = b_valid && exp_rdy(1);
        bc[0] = a_bcast; bc[1] = b_bcast;
        sel[0] = int'(a_sel); sel[1] = int'(b_sel);
        dat[0] = a_data; dat[1] = b_data;
        r[0] = ordy(0); r[1] = ordy(1);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nch(d); i++) begin
                if (acc[d] && (bc[d] || sel[d] == i)) begin
                    mv[d][i] = 1'b1;
                    md[d][i] = dat[d];
                end else if (mv[d][i] && r[d][i]) begin
                    mv[d][i] = 1'b0;
                end
            end
            merr[d] = acc[d] && !bc[d] && (sel[d] >= nch(d));
            if (merr[d] && mcnt[d] < 255) mcnt[d]++;
        end
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_bcast = 0; a_sel = 0; a_data = 0; a_oready = 4'hF;
        b_valid = 0; b_bcast = 0; b_sel = 0; b_data = 0; b_oready = 3'h7;
    endtask

    task automatic test_reset();
        idle();
        a_oready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1; a_sel = 2'(k); a_data = 8'hC0 + 8'(k);
            tick();
        end
        cmp++;
        if (a_ovalid !== 4'hF) begin
            bad++; $display("FAIL fill_before_reset got %h want %h", a_ovalid, 4'hF);
        end
        a_valid = 0;
        #2 rst_n = 0;
        #1;
        model_clear();
        cmp++;
        if (a_ovalid !== 4'h0) begin
            bad++; $display("FAIL reset_valid got %h want 0", a_ovalid);
        end
        cmp++;
        if (a_odata !== 32'h0) begin
            bad++; $display("FAIL reset_data got %h want 0", a_odata);
        end
        cmp++;
        if (a_cnt !== 8'h0 || b_cnt !== 8'h0 || a_err !== 1'b0) begin
            bad++; $display("FAIL reset_cnt got %h/%h want 0", a_cnt, b_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        for (int k = 0; k < 5; k++) begin
            a_bcast = (k == 4); a_sel = 2'(k % 4);
            #1;
            cmp++;
            if (a_ready !== 1'b1) begin
                bad++; $display("FAIL ready_after_reset sel%0d got %b want 1", k, a_ready);
            end
        end
        a_bcast = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unicast_sweep();
        idle();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1; a_sel = 2'(k); a_data = 8'hA0 + 8'(k);
            #1;
            cmp++;
            if (a_ready !== 1'b1) begin
                bad++; $display("FAIL sweep_ready%0d got %b want 1", k, a_ready);
            end
            tick();
            cmp++;
            if (a_ovalid[k] !== 1'b1 || a_odata[k*8 +: 8] !== 8'hA0 + 8'(k)) begin
                bad++; $display("FAIL sweep_ch%0d got %b/%h want 1/%h",
                                k, a_ovalid[k], a_odata[k*8 +: 8], 8'hA0 + 8'(k));
            end
        end
        a_valid = 0;
        tick();
        cmp++;
        if (a_ovalid !== 4'h0) begin
            bad++; $display("FAIL sweep_drain got %h want 0", a_ovalid);
        end
    endtask

    task automatic test_backpressure();
        idle();
        a_oready = 4'b1011;
        a_valid = 1; a_sel = 2; a_data = 8'h11;
        tick();
        a_data = 8'h22;
        #1;
        cmp++;
        if (a_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ready_stall got %b want 0", a_ready);
        end
        tick();
        cmp++;
        if (a_ovalid[2] !== 1'b1 || a_odata[23:16] !== 8'h11) begin
            bad++; $display("FAIL bp_hold got %b/%h want 1/11", a_ovalid[2], a_odata[23:16]);
        end
        a_sel = 1; a_data = 8'h33;
        #1;
        cmp++;
        if (a_ready !== 1'b1) begin
            bad++; $display("FAIL bp_other_ready got %b want 1", a_ready);
        end
        tick();
        cmp++;
        if (a_ovalid[1] !== 1'b1 || a_odata[15:8] !== 8'h33) begin
            bad++; $display("FAIL bp_other_ch got %b/%h want 1/33", a_ovalid[1], a_odata[15:8]);
        end
        a_sel = 2; a_data = 8'h22; a_oready = 4'hF;
        tick();
        cmp++;
        if (a_ovalid[2] !== 1'b1 || a_odata[23:16] !== 8'h22) begin
            bad++; $display("FAIL bp_release got %b/%h want 1/22", a_ovalid[2], a_odata[23:16]);
        end
        a_oready = 4'b1011;
        a_valid = 0;
        tick();
    endtask

    task automatic test_broadcast();
        a_valid = 1; a_bcast = 1; a_data = 8'h5A; a_oready = 4'b1011;
        for (int k = 0; k < 2; k++) begin
            #1;
            cmp++;
            if (a_ready !== 1'b0) begin
                bad++; $display("FAIL bcast_stall%0d got %b want 0", k, a_ready);
            end
            tick();
        end
        a_oready = 4'hF;
        #1;
        cmp++;
        if (a_ready !== 1'b1) begin
            bad++; $display("FAIL bcast_ready got %b want 1", a_ready);
        end
        tick();
        cmp++;
        if (a_ovalid !== 4'hF || a_odata !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL bcast_all got %h/%h want f/5a5a5a5a", a_ovalid, a_odata);
        end
        a_bcast = 0; a_valid = 0;
    endtask

    task automatic test_load_drain();
        a_oready = 4'hF; a_valid = 1; a_sel = 0; a_data = 8'h77;
        #1;
        cmp++;
        if (a_ready !== 1'b1 || a_ovalid[0] !== 1'b1) begin
            bad++; $display("FAIL ld_ready got %b/%b want 1/1", a_ready, a_ovalid[0]);
        end
        tick();
        cmp++;
        if (a_ovalid[0] !== 1'b1 || a_odata[7:0] !== 8'h77) begin
            bad++; $display("FAIL ld_nobubble got %b/%h want 1/77", a_ovalid[0], a_odata[7:0]);
        end
        a_valid = 0;
        tick();
    endtask

    task automatic test_out_of_range();
        idle();
        b_valid = 1; b_sel = 3; b_data = 8'hEE;
        #1;
        cmp++;
        if (b_ready !== 1'b1) begin
            bad++; $display("FAIL oor_ready got %b want 1", b_ready);
        end
        tick();
        cmp++;
        if (b_ovalid !== 3'b0 || b_err !== 1'b1 || b_cnt !== 8'd1) begin
            bad++; $display("FAIL oor_first got v%h e%b c%0d want v0 e1 c1", b_ovalid, b_err, b_cnt);
        end
        b_valid = 0;
        tick();
        cmp++;
        if (b_err !== 1'b0) begin
            bad++; $display("FAIL oor_pulse got %b want 0", b_err);
        end
        b_valid = 1;
        for (int k = 0; k < 300; k++) begin
            tick();
            cmp++;
            if (b_cnt !== 8'(mcnt[1]) || b_err !== 1'b1 || b_ovalid !== 3'b0) begin
                bad++; $display("FAIL oor_burst%0d got c%0d e%b want c%0d e1", k, b_cnt, b_err, mcnt[1]);
            end
        end
        cmp++;
        if (b_cnt !== 8'd255) begin
            bad++; $display("FAIL oor_sat got %0d want 255", b_cnt);
        end
        b_sel = 1; b_data = 8'h42;
        tick();
        cmp++;
        if (b_err !== 1'b0 || b_cnt !== 8'd255 || b_ovalid !== 3'b010) begin
            bad++; $display("FAIL oor_after got e%b c%0d v%h want e0 c255 v2", b_err, b_cnt, b_ovalid);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            a_valid = ($urandom_range(9) < 7); a_bcast = ($urandom_range(5) == 0);
            a_sel = 2'($urandom); a_data = 8'($urandom); a_oready = 4'($urandom);
            b_valid = ($urandom_range(9) < 7); b_bcast = ($urandom_range(5) == 0);
            b_sel = 2'($urandom); b_data = 8'($urandom); b_oready = 3'($urandom);
            #1;
            cmp++;
            if (a_ready !== exp_rdy(0) || b_ready !== exp_rdy(1)) begin
                bad++; $display("FAIL rnd_ready%0d got %b%b want %b%b",
                                k, a_ready, b_ready, exp_rdy(0), exp_rdy(1));
            end
            tick();
            cmp++;
            if (a_ovalid !== pv(0) || a_odata !== pd(0) || a_err !== merr[0]
                || a_cnt !== 8'(mcnt[0])) begin
                bad++; $display("FAIL rnd_a%0d got %h/%h/%b/%0d want %h/%h/%b/%0d", k,
                                a_ovalid, a_odata, a_err, a_cnt, pv(0), pd(0), merr[0], mcnt[0]);
            end
            cmp++;
            if ({1'b0, b_ovalid} !== pv(1) || {8'h0, b_odata} !== pd(1)
                || b_err !== merr[1] || b_cnt !== 8'(mcnt[1])) begin
                bad++; $display("FAIL rnd_b%0d got %h/%h/%b/%0d want %h/%h/%b/%0d", k,
                                b_ovalid, b_odata, b_err, b_cnt, pv(1), pd(1), merr[1], mcnt[1]);
            end
        end
        idle();
    endtask

    initial begin
        model_clear();
        idle();
        #12 rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_unicast_sweep();
        test_backpressure();
        test_broadcast();
        test_load_drain();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/seq_demux.md
# seq_demux

Parametrised, registered 1-to-N demultiplexer with valid/ready handshakes. It is the clocked successor of the 4-way combinational demux. A single input stream is steered by a select field to one of N_OUT output channels, or broadcast to all of them. Each channel has a one-entry output register, so downstream back-pressure is honoured per channel. The block sits between a single producer and N independent consumers in the lab datapath.

## Interface
- DATA_W, 8, payload width in bits (1..32)
- N_OUT, 4, number of output channels (2..16; need not be a power of two)
- SEL_W, $clog2(N_OUT), select width (derived; do not override)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally
- in_valid  input  1  producer has a transaction
- in_ready  output  1  block accepts the transaction this cycle
- in_sel  input  SEL_W  destination channel index
- in_bcast  input  1  1 = deliver to all channels; in_sel ignored
- in_data  input  DATA_W  payload
- out_valid  output  N_OUT  per-channel valid; bit i = channel i
- out_ready  input  N_OUT  per-channel consumer ready
- out_data  output  N_OUT*DATA_W  flat; channel i occupies bits [i*DATA_W +: DATA_W]
- err_sel  output  1  one-cycle pulse: an out-of-range select was accepted and dropped
- drop_cnt  output  8  saturating count of dropped transactions

## Operation
- Each channel i has a slot: valid_q[i] and data_q[i]. out_valid[i] = valid_q[i] and out_data slice i = data_q[i], both driven directly from registers.
- A channel can take data when !valid_q[i] || out_ready[i].
- in_ready is combinational and independent of in_valid:
  - broadcast: AND over all channels of "can take data";
  - unicast, in_sel < N_OUT: "can take data" of channel in_sel;
  - unicast, in_sel >= N_OUT: 1.
- Accept = in_valid && in_ready.
- Unicast accept to a valid channel: the target slot loads in_data and sets valid_q.
- Broadcast accept: every slot loads in_data and sets valid_q.
- Unicast accept with in_sel >= N_OUT: no slot changes. err_sel pulses and drop_cnt increments, saturating at 255.
- Per-slot update priority:
  - load on accept: valid_q=1 (load wins over drain in the same cycle);
  - else drain (out_valid[i] && out_ready[i]): valid_q=0 and data_q holds its last value;
  - else hold.
- Slots are independent. A stalled channel never blocks unicast traffic to other channels; it blocks only broadcasts.
- Ordering per channel is preserved because each channel holds a single entry.
- Reset (async, any time, including mid-transfer): valid_q=0, data_q=0, err_sel=0, drop_cnt=0. Pending slot contents are discarded. in_ready after reset is 1 for every select and for broadcast.

## Timing
- Latency: data accepted at edge k appears on out_data/out_valid after edge k. It is visible in cycle k+1.
- Throughput: 1 transaction/cycle per channel when its out_ready is held high (drain and load in the same cycle).
- The in_ready to out_ready path is combinational, with no register stage. Producers must not make in_valid depend on in_ready.
- err_sel is registered: high for exactly the cycle after the dropping accept. It is 0 otherwise, including on back-to-back valid accepts.
- drop_cnt updates on the same edge as err_sel. At 255 it stays 255 while err_sel still pulses.
- out_valid[i], once high, stays high with stable out_data until out_ready[i] is sampled high (standard valid/ready rule).

## Test plan
- Reset, DATA_W=8, N_OUT=4: drive rst_n=0 mid-stream with slots full -> all out_valid=0, out_data=0, drop_cnt=0 immediately, without waiting for a clock edge. in_ready=1 after release.
- Unicast sweep, all out_ready=1: send 0xA0..0xA3 to sel 0..3 on consecutive cycles -> each appears on its own channel one cycle later, one per cycle, no stalls.
- Back-pressure: out_ready[2]=0. Send 0x11 to sel 2, then 0x22 to sel 2, then 0x33 to sel 1 -> 0x11 held on ch2 and in_ready=0 for the second sel 2. 0x33 is still accepted and appears on ch1. Releasing out_ready[2] delivers 0x22 next.
- Broadcast: out_ready=4'b1011 with ch2 full, send 0x5A with in_bcast=1 -> in_ready=0 until ch2 drains. Then all four channels show 0x5A together.
- Out-of-range, N_OUT=3: send in_sel=3 -> in_ready=1, no out_valid rises, err_sel high one cycle, drop_cnt=1. Send 300 such drops -> drop_cnt=255.
- Simultaneous load/drain: ch0 full with out_ready[0]=1, accept 0x77 to sel 0 in the same cycle -> next cycle out_valid[0]=1 and out_data ch0=0x77, no bubble.
